// File: rtl/lookup_scheduler.sv
// Queues parsed headers and issues them one at a time to a shared lookup table,
// reporting hit/miss or timeout for each and counting drops and timeouts.
`ifndef OF_HEADER_REG_WIDTH
`define OF_HEADER_REG_WIDTH 64
`endif

module lookup_scheduler #(
    parameter int HDR_WIDTH  = `OF_HEADER_REG_WIDTH,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [HDR_WIDTH-1:0]          header_bus,
    input  logic                          headers_valid,
    output logic                          lookup_req,
    output logic [HDR_WIDTH-1:0]          lookup_hdr,
    input  logic                          lookup_ack,
    input  logic                          lookup_hit,
    output logic                          result_valid,
    output logic                          result_hit,
    output logic                          result_timeout,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [15:0]                   drop_count,
    output logic [15:0]                   timeout_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t               state;
    logic                 valid_d;
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [TMR_W-1:0]     timer;
    logic [HDR_WIDTH-1:0] mem [FIFO_DEPTH];

    logic capture;
    logic full;
    logic push;
    logic pop;

    // A header is taken once per rising edge of the level-style headers_valid.
    assign capture = headers_valid && !valid_d;
    assign full    = (fifo_count == CNT_W'(FIFO_DEPTH));
    assign push    = capture && !full;
    assign pop     = (state == IDLE) && (fifo_count != '0);

    // NOTE: the storage array has no reset; the pointers and count alone decide
    // which entries are meaningful, and leaving it unreset keeps it a plain RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= header_bus;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            valid_d        <= 1'b1;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            fifo_count     <= '0;
            timer          <= '0;
            lookup_req     <= 1'b0;
            lookup_hdr     <= '0;
            result_valid   <= 1'b0;
            result_hit     <= 1'b0;
            result_timeout <= 1'b0;
            drop_count     <= '0;
            timeout_count  <= '0;
        end else begin
            valid_d      <= headers_valid;
            result_valid <= 1'b0;

            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase

            // A full queue drops the arrival even if the head leaves on this edge.
            if (capture && full && drop_count != 16'hFFFF) begin
                drop_count <= drop_count + 16'd1;
            end

            case (state)
                IDLE: begin
                    if (pop) begin
                        lookup_hdr <= mem[rd_ptr];
                        lookup_req <= 1'b1;
                        timer      <= '0;
                        state      <= BUSY;
                    end
                end
                BUSY: begin
                    // An ack on the expiry cycle wins over the timeout.
                    if (lookup_ack) begin
                        lookup_req     <= 1'b0;
                        result_valid   <= 1'b1;
                        result_hit     <= lookup_hit;
                        result_timeout <= 1'b0;
                        state          <= IDLE;
                    end else if (timer == TMR_W'(TIMEOUT - 1)) begin
                        lookup_req     <= 1'b0;
                        result_valid   <= 1'b1;
                        result_hit     <= 1'b0;
                        result_timeout <= 1'b1;
                        state          <= IDLE;
                        if (timeout_count != 16'hFFFF) begin
                            timeout_count <= timeout_count + 16'd1;
                        end
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lookup_scheduler.sv
// Randomized bench for lookup_scheduler: a queue-based reference model predicts
// per-cycle status and the ordered result stream, checked by a separate monitor.
module tb_lookup_scheduler;

    localparam int HW    = 32;
    localparam int DEPTH = 4;
    localparam int TO    = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [HW-1:0] header_bus = '0;
    logic          headers_valid = 1'b1;
    logic          lookup_req;
    logic [HW-1:0] lookup_hdr;
    logic          lookup_ack = 1'b0;
    logic          lookup_hit = 1'b0;
    logic          result_valid;
    logic          result_hit;
    logic          result_timeout;
    logic [2:0]    fifo_count;
    logic [15:0]   drop_count;
    logic [15:0]   timeout_count;

    lookup_scheduler #(.HDR_WIDTH(HW), .FIFO_DEPTH(DEPTH), .TIMEOUT(TO)) dut (
        .clk           (clk),
        .reset         (reset),
        .header_bus    (header_bus),
        .headers_valid (headers_valid),
        .lookup_req    (lookup_req),
        .lookup_hdr    (lookup_hdr),
        .lookup_ack    (lookup_ack),
        .lookup_hit    (lookup_hit),
        .result_valid  (result_valid),
        .result_hit    (result_hit),
        .result_timeout(result_timeout),
        .fifo_count    (fifo_count),
        .drop_count    (drop_count),
        .timeout_count (timeout_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [HW-1:0] hdr;
        logic          hit;
        logic          to;
    } res_t;

    int   checks = 0;
    int   failures = 0;
    res_t exp_q[$];

    // Reference model state: headers waiting, the one in flight, and counters.
    logic [HW-1:0] m_q[$];
    bit            m_busy = 1'b0;
    int            m_age = 0;
    int            m_lat = 0;
    bit            m_hit = 1'b0;
    logic [HW-1:0] m_hdr = '0;
    bit            m_prev_v = 1'b1;
    bit            m_req = 1'b0;
    bit            m_rv = 1'b0;
    logic [15:0]   m_drops = '0;
    logic [15:0]   m_tos = '0;

    // Responder controls: fixed_lat < 0 random, 0 never ack; fixed_hit < 0 random.
    int fixed_lat = 0;
    int fixed_hit = 0;
    bit stray_en = 1'b0;
    bit preset_drops = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit rst, input bit hv, input logic [HW-1:0] hdr,
                              input bit ack, input bit hit);
        bit cap;
        bit was_full;
        if (rst) begin
            m_q.delete();
            m_busy   = 1'b0;
            m_prev_v = 1'b1;
            m_req    = 1'b0;
            m_rv     = 1'b0;
            m_drops  = '0;
            m_tos    = '0;
            return;
        end
        cap      = hv && !m_prev_v;
        m_prev_v = hv;
        was_full = (m_q.size() == DEPTH);
        m_rv     = 1'b0;
        if (m_busy) begin
            if (ack) begin
                exp_q.push_back('{hdr: m_hdr, hit: hit, to: 1'b0});
                m_busy = 1'b0; m_req = 1'b0; m_rv = 1'b1;
            end else if (m_age == TO) begin
                exp_q.push_back('{hdr: m_hdr, hit: 1'b0, to: 1'b1});
                if (m_tos != 16'hFFFF) m_tos = m_tos + 16'd1;
                m_busy = 1'b0; m_req = 1'b0; m_rv = 1'b1;
            end else begin
                m_age++;
            end
        end else if (m_q.size() > 0) begin
            m_hdr  = m_q.pop_front();
            m_busy = 1'b1;
            m_req  = 1'b1;
            m_age  = 1;
            m_lat  = (fixed_lat < 0) ? int'($urandom_range(1, TO + 3)) : fixed_lat;
            m_hit  = (fixed_hit < 0) ? bit'($urandom_range(0, 1)) : fixed_hit[0];
        end
        if (cap) begin
            if (was_full) begin
                if (m_drops != 16'hFFFF) m_drops = m_drops + 16'd1;
            end else begin
                m_q.push_back(hdr);
            end
        end
    endtask

    task automatic tick(input bit hv, input logic [HW-1:0] hdr, input bit rst);
        bit ack;
        bit hit;
        @(negedge clk);
        if (m_busy && m_age == m_lat) begin
            ack = 1'b1;
            hit = m_hit;
        end else begin
            ack = !m_busy && stray_en && ($urandom_range(0, 3) == 0);
            hit = bit'($urandom_range(0, 1));
        end
        reset         = rst;
        headers_valid = hv;
        header_bus    = hdr;
        lookup_ack    = ack;
        lookup_hit    = hit;
        if (preset_drops) begin
            force dut.drop_count = 16'hFFF0;
            #1;
            release dut.drop_count;
            m_drops      = 16'hFFF0;
            preset_drops = 1'b0;
        end
        model_step(rst, hv, hdr, ack, hit);
        @(posedge clk);
        #1;
        check("lookup_req", lookup_req, m_req);
        check("result_valid", result_valid, m_rv);
        check("fifo_count", fifo_count, m_q.size());
        check("drop_count", drop_count, m_drops);
        check("timeout_count", timeout_count, m_tos);
        if (m_req) check("lookup_hdr", lookup_hdr, m_hdr);
    endtask

    task automatic send(input logic [HW-1:0] hdr, input int hi, input int lo);
        repeat (hi) tick(1'b1, hdr, 1'b0);
        repeat (lo) tick(1'b0, HW'($urandom), 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0, HW'($urandom), 1'b0);
    endtask

    // Result monitor: consumes the expected stream whenever the DUT strobes.
    initial begin
        res_t e;
        forever begin
            @(negedge clk);
            if (result_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("result_hdr", lookup_hdr, e.hdr);
                    check("result_hit", result_hit, e.hit);
                    check("result_timeout", result_timeout, e.to);
                end
            end
        end
    end

    initial begin
        // Reset with headers_valid held high, then no capture until it toggles.
        repeat (3) tick(1'b1, 32'h1111_1111, 1'b1);
        repeat (3) tick(1'b1, 32'h2222_2222, 1'b0);
        idle(2);

        // Single header, ack on the third request cycle with a hit.
        fixed_lat = 3; fixed_hit = 1;
        send(32'hA5A5_0001, 1, 1);
        idle(6);

        // No ack: timeout after TO request cycles.
        fixed_lat = 0;
        send(32'hA5A5_0002, 1, 1);
        idle(12);

        // Ack on the expiry cycle counts as an ack.
        fixed_lat = TO; fixed_hit = 1;
        send(32'hA5A5_0003, 2, 1);
        idle(12);

        // Six back-to-back arrivals while acks are withheld: queue fills, one drops.
        fixed_lat = 0;
        for (int i = 0; i < 6; i++) send(32'hB000_0000 + i, 1, 1);
        idle(60);

        // Reset mid-request with headers_valid held high, stray acks afterwards.
        send(32'hC0DE_0001, 4, 0);
        repeat (2) tick(1'b1, 32'hC0DE_0001, 1'b1);
        stray_en = 1'b1;
        repeat (5) tick(1'b1, 32'hC0DE_0001, 1'b0);
        idle(2);
        stray_en = 1'b0;
        fixed_lat = 2; fixed_hit = 0;
        send(32'hC0DE_0002, 1, 1);
        idle(6);

        // Randomized traffic, latencies, hits and stray acks.
        fixed_lat = -1; fixed_hit = -1; stray_en = 1'b1;
        for (int i = 0; i < 300; i++) begin
            send(HW'($urandom), int'($urandom_range(1, 3)), int'($urandom_range(1, 6)));
        end
        idle(40);

        // Drop counter preset near saturation, then flooded with drops.
        stray_en = 1'b0; fixed_lat = 0;
        preset_drops = 1'b1;
        for (int i = 0; i < 40; i++) send(32'hD000_0000 + i, 1, 1);
        check("drop_saturated", drop_count, 16'hFFFF);
        idle(60);

        check("results_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
